// File: rtl/tty_uart.sv
// rtl/tty_uart.sv - UART terminal endpoint: RX strobe with error flags, TX serialiser
// Ports:
//   sys_clk_i, rst_n        : clock and synchronous active-low reset
//   SRX                     : asynchronous serial input (from SoC UART TX)
//   STX                     : registered serial output (to SoC UART RX), idles high
//   tx_data/tx_valid/tx_ready : character send handshake, accepted only when idle
//   rx_data/rx_valid        : received character with one-cycle strobe
//   rx_frame_err/rx_parity_err : error flags qualified by rx_valid
module tty_uart #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200,
    parameter int PARITY   = 0
) (
    input  logic       sys_clk_i,
    input  logic       rst_n,
    input  logic       SRX,
    output logic       STX,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err
);

    localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    // Unsupported PARITY values fall back to no parity.
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q,   tx_cnt_d;
    logic [2:0]      tx_idx_q,   tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_par_q,   tx_par_d;
    logic            stx_q,      stx_d;

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            stx_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            stx_q      <= stx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        stx_d      = stx_q;

        unique case (tx_state_q)
            ST_IDLE: begin
                stx_d = 1'b1;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    // Parity is fixed at acceptance since the shifter consumes the data.
                    tx_par_d   = (^tx_data) ^ PAR_ODD;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                    stx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = ST_DATA;
                    stx_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_idx_q == 3'd7) begin
                        if (PAR_EN) begin
                            tx_state_d = ST_PAR;
                            stx_d      = tx_par_q;
                        end else begin
                            tx_state_d = ST_STOP;
                            stx_d      = 1'b1;
                        end
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        stx_d    = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_PAR: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                    stx_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                    stx_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                stx_d      = 1'b1;
            end
        endcase
    end

    assign STX      = stx_q;
    assign tx_ready = (tx_state_q == ST_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    // sync1/sync2 form the synchroniser; sync3 is the previous synchronised
    // value used for falling-edge detection.
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            sync3_q, sync3_d;
    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q,   rx_cnt_d;
    logic [2:0]      rx_idx_q,   rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_pbit_q,  rx_pbit_d;
    logic [7:0]      rx_data_q,  rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q,  rx_ferr_d;
    logic            rx_perr_q,  rx_perr_d;
    logic            rx_fall;

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sync3_q    <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_pbit_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_pbit_q  <= rx_pbit_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // A held-low line never produces a new fall, so a break yields one strobe.
    assign rx_fall = sync3_q & ~sync2_q;

    always_comb begin
        sync1_d    = SRX;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_pbit_d  = rx_pbit_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;

        unique case (rx_state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                // Half-bit sample re-checks the start bit to reject glitches.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    if (sync2_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = PAR_EN ? ST_PAR : ST_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_PAR: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_pbit_d  = sync2_q;
                    rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    rx_ferr_d  = ~sync2_q;
                    rx_perr_d  = PAR_EN ? (((^rx_shift_q) ^ rx_pbit_q) != PAR_ODD) : 1'b0;
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;

endmodule

// File: tb/tb_tty_uart.sv
// tb/tb_tty_uart.sv - scoreboard bench for tty_uart (no-parity and even-parity instances)
module tb_tty_uart;

    localparam int DIV  = (25000000 + 115200 / 2) / 115200;
    localparam int HALF = DIV / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Default instance
    logic       srx, srx_drv = 1'b1, loop_en = 1'b0;
    logic       stx;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, rx_perr;

    // Even-parity instance
    logic       psrx = 1'b1;
    logic       pstx;
    logic [7:0] ptx_data = 8'h00;
    logic       ptx_valid = 1'b0;
    logic       ptx_ready;
    logic [7:0] prx_data;
    logic       prx_valid, prx_ferr, prx_perr;

    int checks = 0;
    int failures = 0;
    int strobes = 0;
    int pstrobes = 0;

    // Scoreboard entries: {data[7:0], frame_err, parity_err}
    logic [9:0] exp_q[$];
    logic [9:0] exp_pq[$];
    logic [9:0] e, pe;

    assign srx = loop_en ? stx : srx_drv;

    always #20 clk = ~clk;

    tty_uart u_dut (
        .sys_clk_i    (clk),
        .rst_n        (rst_n),
        .SRX          (srx),
        .STX          (stx),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_ferr),
        .rx_parity_err(rx_perr)
    );

    tty_uart #(.PARITY(1)) u_par (
        .sys_clk_i    (clk),
        .rst_n        (rst_n),
        .SRX          (psrx),
        .STX          (pstx),
        .tx_data      (ptx_data),
        .tx_valid     (ptx_valid),
        .tx_ready     (ptx_ready),
        .rx_data      (prx_data),
        .rx_valid     (prx_valid),
        .rx_frame_err (prx_ferr),
        .rx_parity_err(prx_perr)
    );

    // Receive monitors: every strobe must match the head of its scoreboard.
    always @(negedge clk) begin
        if (rx_valid) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected: got data=%02h ferr=%0b perr=%0b, expected no strobe",
                         rx_data, rx_ferr, rx_perr);
            end else begin
                e = exp_q.pop_front();
                if ({rx_data, rx_ferr, rx_perr} !== e) begin
                    failures++;
                    $display("FAIL rx_frame: got data=%02h ferr=%0b perr=%0b, expected data=%02h ferr=%0b perr=%0b",
                             rx_data, rx_ferr, rx_perr, e[9:2], e[1], e[0]);
                end
            end
        end
        if (prx_valid) begin
            pstrobes++;
            checks++;
            if (exp_pq.size() == 0) begin
                failures++;
                $display("FAIL prx_unexpected: got data=%02h ferr=%0b perr=%0b, expected no strobe",
                         prx_data, prx_ferr, prx_perr);
            end else begin
                pe = exp_pq.pop_front();
                if ({prx_data, prx_ferr, prx_perr} !== pe) begin
                    failures++;
                    $display("FAIL prx_frame: got data=%02h ferr=%0b perr=%0b, expected data=%02h ferr=%0b perr=%0b",
                             prx_data, prx_ferr, prx_perr, pe[9:2], pe[1], pe[0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 20 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            failures++;
            $display("FAIL send_wait: tx_ready=%0b, expected 1 within %0d cycles", tx_ready, 20 * DIV);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit use_par, input bit par_bit,
                               input bit stop_bit, input int bitlen, input bit to_par);
        logic [10:0] bits;
        int nb;
        bits = use_par ? {stop_bit, par_bit, d, 1'b0} : {1'b0, stop_bit, d, 1'b0};
        nb   = use_par ? 11 : 10;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (to_par) psrx = bits[i];
            else        srx_drv = bits[i];
            repeat (bitlen - 1) @(negedge clk);
        end
        @(negedge clk);
        if (to_par) psrx = 1'b1;
        else        srx_drv = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || exp_pq.size() != 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_pq.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: pending=%0d/%0d, expected 0/0 within %0d cycles",
                     name, exp_q.size(), exp_pq.size(), max_cycles);
        end
    endtask

    task automatic test_reset();
        int s0;
        rst_n = 1'b0;
        repeat (400) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({stx, tx_ready, rx_valid, rx_data, rx_ferr, rx_perr} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: stx=%0b rdy=%0b rxv=%0b rxd=%02h fe=%0b pe=%0b, expected 1 1 0 00 0 0",
                     stx, tx_ready, rx_valid, rx_data, rx_ferr, rx_perr);
        end
        checks++;
        if ({pstx, ptx_ready, prx_valid} !== 3'b110) begin
            failures++;
            $display("FAIL reset_par: stx=%0b rdy=%0b rxv=%0b, expected 1 1 0", pstx, ptx_ready, prx_valid);
        end
        s0 = strobes + pstrobes;
        repeat (1000) @(negedge clk);
        checks++;
        if (strobes + pstrobes !== s0) begin
            failures++;
            $display("FAIL reset_idle: strobes=%0d, expected %0d", strobes + pstrobes, s0);
        end
    endtask

    task automatic test_tx_frame();
        logic [9:0] pat;
        bit ready_ok = 1'b1;
        pat = {1'b1, 8'h55, 1'b0};
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 10 * DIV; k++) begin
            if (tx_ready !== 1'b0) ready_ok = 1'b0;
            if ((k % DIV) == 0 || (k % DIV) == DIV - 1) begin
                checks++;
                if (stx !== pat[k / DIV]) begin
                    failures++;
                    $display("FAIL tx_bit: bit=%0d cycle=%0d stx=%0b, expected %0b", k / DIV, k, stx, pat[k / DIV]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (!ready_ok) begin
            failures++;
            $display("FAIL tx_ready_low: tx_ready seen high inside frame, expected low for %0d cycles", 10 * DIV);
        end
        checks++;
        if ({tx_ready, stx} !== 2'b11) begin
            failures++;
            $display("FAIL tx_done: tx_ready=%0b stx=%0b, expected 1 1", tx_ready, stx);
        end
    endtask

    task automatic test_loopback();
        int s0 = strobes;
        loop_en = 1'b1;
        exp_q.push_back({8'h48, 2'b00});
        exp_q.push_back({8'h0A, 2'b00});
        send_byte(8'h48);
        send_byte(8'h0A);
        wait_drain("loopback", 30 * DIV);
        repeat (DIV) @(negedge clk);
        checks++;
        if (strobes - s0 !== 2) begin
            failures++;
            $display("FAIL loopback_count: strobes=%0d, expected 2", strobes - s0);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_frame_err();
        exp_q.push_back({8'hA3, 2'b10});
        drive_frame(8'hA3, 1'b0, 1'b0, 1'b0, DIV, 1'b0);
        wait_drain("frame_err", 3 * DIV);
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic test_glitch();
        int s0 = strobes;
        @(negedge clk);
        srx_drv = 1'b0;
        repeat (50) @(negedge clk);
        srx_drv = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        checks++;
        if (strobes !== s0) begin
            failures++;
            $display("FAIL glitch_strobe: strobes=%0d, expected %0d", strobes, s0);
        end
        exp_q.push_back({8'h3C, 2'b00});
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b1, DIV, 1'b0);
        wait_drain("after_glitch", 3 * DIV);
    endtask

    task automatic test_break();
        int s0 = strobes;
        exp_q.push_back({8'h00, 2'b10});
        @(negedge clk);
        srx_drv = 1'b0;
        repeat (30 * DIV) @(negedge clk);
        checks++;
        if (strobes - s0 !== 1) begin
            failures++;
            $display("FAIL break_count: strobes=%0d, expected 1", strobes - s0);
        end
        srx_drv = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        exp_q.push_back({8'hC5, 2'b00});
        drive_frame(8'hC5, 1'b0, 1'b0, 1'b1, DIV, 1'b0);
        wait_drain("after_break", 3 * DIV);
    endtask

    task automatic test_baud_tol();
        exp_q.push_back({8'h96, 2'b00});
        drive_frame(8'h96, 1'b0, 1'b0, 1'b1, (DIV * 102) / 100, 1'b0);
        wait_drain("baud_slow", 3 * DIV);
        repeat (DIV) @(negedge clk);
        exp_q.push_back({8'h69, 2'b00});
        drive_frame(8'h69, 1'b0, 1'b0, 1'b1, (DIV * 98) / 100, 1'b0);
        wait_drain("baud_fast", 3 * DIV);
        repeat (DIV) @(negedge clk);
    endtask

    task automatic check_ptx(input logic [7:0] d, input logic exp_par);
        @(negedge clk);
        ptx_data  = d;
        ptx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ptx_valid = 1'b0;
        // now in cycle T+1
        repeat (9 * DIV + HALF) @(negedge clk);
        checks++;
        if (pstx !== exp_par) begin
            failures++;
            $display("FAIL ptx_parity: data=%02h stx=%0b, expected %0b", d, pstx, exp_par);
        end
        repeat (DIV) @(negedge clk);
        checks++;
        if ({pstx, ptx_ready} !== 2'b10) begin
            failures++;
            $display("FAIL ptx_stop: stx=%0b rdy=%0b, expected 1 0", pstx, ptx_ready);
        end
        repeat (DIV - HALF) @(negedge clk);
        checks++;
        if (ptx_ready !== 1'b1) begin
            failures++;
            $display("FAIL ptx_ready: rdy=%0b, expected 1 at 11 bit times", ptx_ready);
        end
    endtask

    task automatic test_parity();
        exp_pq.push_back({8'h07, 2'b00});
        drive_frame(8'h07, 1'b1, 1'b1, 1'b1, DIV, 1'b1);
        wait_drain("parity_ok", 3 * DIV);
        repeat (DIV) @(negedge clk);
        exp_pq.push_back({8'h07, 2'b01});
        drive_frame(8'h07, 1'b1, 1'b0, 1'b1, DIV, 1'b1);
        wait_drain("parity_bad", 3 * DIV);
        repeat (DIV) @(negedge clk);
        check_ptx(8'h07, 1'b1);
        check_ptx(8'h03, 1'b0);
    endtask

    task automatic test_reset_midframe();
        int s0;
        send_byte(8'hA5);
        s0 = strobes;
        srx_drv = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rst_n = 1'b0;
        srx_drv = 1'b1;
        @(negedge clk);
        checks++;
        if ({stx, tx_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_tx: stx=%0b rdy=%0b, expected 1 1", stx, tx_ready);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (15 * DIV) @(negedge clk);
        checks++;
        if (strobes !== s0) begin
            failures++;
            $display("FAIL reset_mid_rx: strobes=%0d, expected %0d", strobes, s0);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_frame_err();
        test_glitch();
        test_break();
        test_baud_tol();
        test_parity();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0 || exp_pq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: pending=%0d/%0d, expected 0/0", exp_q.size(), exp_pq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tty_uart.md
# tty_uart

Clocked UART terminal endpoint for the SoC testbench. It receives characters the SoC transmits on its UART TX pad and presents each one as a one-cycle strobe with error flags. It also serialises host-supplied characters onto the SoC's UART RX pad. It replaces a purely behavioural serial monitor with a cycle-accurate, synthesisable block running on the 25 MHz oscillator clock.

## Interface
Parameters:
- CLK_FREQ, default 25000000: clock frequency in Hz.
- BAUD, default 115200: line rate in bit/s. DIV = (CLK_FREQ + BAUD/2) / BAUD, which gives 217 at the defaults.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd. Any other value is treated as 0.

Ports (one clock; reset is synchronous and active-low):
- sys_clk_i, input, 1: clock; all logic on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- SRX, input, 1: serial in, from the SoC UART TX; asynchronous.
- STX, output, 1: serial out, to the SoC UART RX; idles high.
- tx_data, input, 8: character to send.
- tx_valid, input, 1: send request.
- tx_ready, output, 1: transmitter idle, able to accept.
- rx_data, output, 8: last received character.
- rx_valid, output, 1: one-cycle strobe, rx_data valid.
- rx_frame_err, output, 1: stop bit sampled low; valid with rx_valid.
- rx_parity_err, output, 1: parity mismatch; valid with rx_valid; always 0 when PARITY = 0.

## Operation
- Frame: start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1). Each bit lasts DIV cycles.
- Transmitter FSM states: IDLE, START, DATA, PAR, STOP.
  - A transfer is accepted when tx_valid && tx_ready in IDLE; tx_data is latched at that point.
  - STX is registered.
  - tx_ready is 1 only in IDLE and drops in the cycle after acceptance.
  - PAR is skipped when PARITY = 0.
  - On completing STOP the FSM returns to IDLE, and tx_ready rises.
  - tx_valid outside IDLE is ignored; no queueing.
- Receiver input path: SRX passes through a 2-flop synchroniser, then edge detection on the synchronised value.
- Receiver FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START on a 1→0 transition of the synchronised line.
  - In START, the line is sampled after DIV/2 cycles (integer division). If it is high, the start is false and the FSM returns to IDLE with no strobe. If it is low, the FSM proceeds.
  - Every subsequent bit is sampled DIV cycles after the previous sample, i.e. at bit centre.
  - Data bits are shifted in LSB first. PAR is skipped when PARITY = 0.
  - At the STOP sample the block updates rx_data, pulses rx_valid for exactly one cycle, sets both error flags for that cycle, and returns to IDLE.
  - A new start edge is accepted from the cycle after the STOP sample.
- Error flags hold their last value between strobes. They are meaningful only when rx_valid = 1.
- A break (line held low) produces one strobe with data 0x00 and rx_frame_err = 1. No further strobes occur until the line has returned high and fallen again.
- Parity: even means XOR of data ^ parity bit == 0; odd means it == 1. TX generates parity under the same rule.
- TX and RX are fully independent, so full-duplex operation is supported.

## Timing
- Reset values: STX = 1, tx_ready = 1, rx_valid = 0, rx_data = 0x00, rx_frame_err = 0, rx_parity_err = 0. Both FSMs go to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame immediately: STX = 1 in the next cycle and no rx_valid is issued.
- TX, with acceptance at edge T:
  - STX goes low at T+1.
  - Data bit i starts at T+1+(i+1)·DIV.
  - Stop starts at T+1+(9+P)·DIV, where P = 1 if parity is enabled, else 0.
  - tx_ready returns high at T+1+(10+P)·DIV.
- RX latency:
  - Synchroniser delay is 2 cycles.
  - rx_valid asserts (9+P)·DIV + DIV/2 + 3 cycles (±1) after the SRX falling edge.
- Baud tolerance: frames must be received correctly with sender rate error up to ±2%.

## Test plan
- Reset check: reset for 400 cycles, then release → STX = 1, tx_ready = 1, rx_valid = 0. Hold for 1000 cycles and confirm no strobes.
- TX frame: with defaults, send 0x55 → STX pattern 0,1,0,1,0,1,0,1,0,1, each bit held 217 cycles. tx_ready is low for 2170 cycles.
- RX loopback: connect STX to SRX and send 0x48 then 0x0A back-to-back → two rx_valid strobes with data 0x48 then 0x0A and no errors.
- Framing error: drive SRX with a frame for 0xA3 whose stop bit is 0 → rx_valid with rx_data = 0xA3 and rx_frame_err = 1.
- Glitch rejection: drive SRX low for 50 cycles, then high → no rx_valid, and the FSM is back in IDLE.
- Parity (PARITY = 1): send 0x07 with a correct parity bit of 1 → rx_parity_err = 0. Send it with the parity bit flipped → rx_parity_err = 1.
